// File: rtl/write_buffer_pkg.sv
// Shared types and default sizing for the store write buffer.
// Drain FSM encoding lives here so the top and bench agree on it.
package write_buffer_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Circular store FIFO: entries, head/tail pointers, occupancy count
// and the youngest-match forwarding compare.
module wb_fifo
  import write_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    pop,
  input  logic [ADDR_WIDTH-1:0]   chk_addr,
  output logic [ADDR_WIDTH-1:0]   head_addr,
  output logic [DATA_WIDTH-1:0]   head_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    fwd_hit,
  output logic [DATA_WIDTH-1:0]   fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [PW-1:0]         idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= wr_addr;
      data_q[tail] <= wr_data;
    end
  end

  assign head_addr = addr_q[head];
  assign head_data = data_q[head];

  // Walk oldest to youngest so the last match seen wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count && addr_q[idx] == chk_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/write_buffer.sv
// Store write buffer: accepts CPU stores, drains them in order to
// data memory, and forwards buffered data to read misses.
module write_buffer
  import write_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_req,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_ready,
  input  logic [ADDR_WIDTH-1:0]   chk_addr,
  output logic                    fwd_hit,
  output logic [DATA_WIDTH-1:0]   fwd_data,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_w_data,
  input  logic                    mem_ack,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_state_e             state;
  wb_state_e             state_nx;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  assign wr_ready = count < CW'(DEPTH);
  assign empty    = count == '0;
  assign push     = wr_req && wr_ready;

  wb_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pop       (pop),
    .chk_addr  (chk_addr),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Entering DRAIN on the push edge gives one-cycle issue latency.
  always_comb begin
    state_nx   = state;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_w_data = '0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (push || !empty) state_nx = DRAIN;
      end
      DRAIN: begin
        mem_wr_en  = 1'b1;
        mem_addr   = head_addr;
        mem_w_data = head_data;
        pop        = mem_ack;
        if (mem_ack && count == CW'(1) && !push)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_write_buffer.sv
// Bench for write_buffer: directed vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_write_buffer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic [AW-1:0] chk_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_w_data;
  logic          mem_ack;
  logic          empty;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  write_buffer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .chk_addr   (chk_addr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_ack    (mem_ack),
    .empty      (empty),
    .count      (count)
  );

  // Reference: FIFO as a queue, draining whenever anything is held.
  logic [AW-1:0] qa[$];
  logic [DW-1:0] qd[$];
  bit            m_drain;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic          hit;
    logic [DW-1:0] fd;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    hit = 1'b0;
    fd  = '0;
    ea  = '0;
    ed  = '0;
    foreach (qa[i]) if (qa[i] == chk_addr) begin
      hit = 1'b1;
      fd  = qd[i];
    end
    if (m_drain) begin
      ea = qa[0];
      ed = qd[0];
    end
    chk("m_ready", 64'(wr_ready), 64'(qa.size() < D));
    chk("m_empty", 64'(empty), 64'(qa.size() == 0));
    chk("m_count", 64'(count), 64'(qa.size()));
    chk("m_wr_en", 64'(mem_wr_en), 64'(m_drain));
    chk("m_addr", 64'(mem_addr), 64'(ea));
    chk("m_data", 64'(mem_w_data), 64'(ed));
    chk("m_hit", 64'(fwd_hit), 64'(hit));
    chk("m_fdata", 64'(fwd_data), 64'(fd));
  endtask

  task automatic model_edge();
    bit do_push;
    if (reset) begin
      qa.delete();
      qd.delete();
      m_drain = 1'b0;
    end else begin
      do_push = wr_req && qa.size() < D;
      if (m_drain && mem_ack) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (do_push) begin
        qa.push_back(wr_addr);
        qd.push_back(wr_data);
      end
      m_drain = qa.size() > 0;
    end
  endtask

  task automatic drive(bit rst, bit wr, logic [AW-1:0] a,
                       logic [DW-1:0] d, bit ack, logic [AW-1:0] c);
    reset    = rst;
    wr_req   = wr;
    wr_addr  = a;
    wr_data  = d;
    mem_ack  = ack;
    chk_addr = c;
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(bit rst, bit wr, logic [AW-1:0] a,
                      logic [DW-1:0] d, bit ack, logic [AW-1:0] c);
    drive(rst, wr, a, d, ack, c);
    model_check();
    tick();
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            ack;
    logic [AW-1:0] c;
    bit            en;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    int            cnt;
    bit            rdy;
    bit            hit;
    logic [DW-1:0] fd;
  } vec_t;

  vec_t tv[25];

  initial begin
    tv[0]  = '{1, 'h10,  'hAA, 0, 'h10,  0, 'h0,   'h0,  0, 1, 0, 'h0};
    tv[1]  = '{0, 'h0,   'h0,  1, 'h10,  1, 'h10,  'hAA, 1, 1, 1, 'hAA};
    tv[2]  = '{0, 'h0,   'h0,  0, 'h10,  0, 'h0,   'h0,  0, 1, 0, 'h0};
    tv[3]  = '{1, 'h100, 'h1,  0, 'h100, 0, 'h0,   'h0,  0, 1, 0, 'h0};
    tv[4]  = '{1, 'h104, 'h2,  0, 'h100, 1, 'h100, 'h1,  1, 1, 1, 'h1};
    tv[5]  = '{1, 'h108, 'h3,  0, 'h104, 1, 'h100, 'h1,  2, 1, 1, 'h2};
    tv[6]  = '{1, 'h10C, 'h4,  0, 'h200, 1, 'h100, 'h1,  3, 1, 0, 'h0};
    tv[7]  = '{1, 'h110, 'h5,  0, 'h110, 1, 'h100, 'h1,  4, 0, 0, 'h0};
    tv[8]  = '{0, 'h0,   'h0,  1, 'h10C, 1, 'h100, 'h1,  4, 0, 1, 'h4};
    tv[9]  = '{0, 'h0,   'h0,  1, 'h100, 1, 'h104, 'h2,  3, 1, 0, 'h0};
    tv[10] = '{0, 'h0,   'h0,  1, 'h108, 1, 'h108, 'h3,  2, 1, 1, 'h3};
    tv[11] = '{0, 'h0,   'h0,  1, 'h10C, 1, 'h10C, 'h4,  1, 1, 1, 'h4};
    tv[12] = '{0, 'h0,   'h0,  1, 'h110, 0, 'h0,   'h0,  0, 1, 0, 'h0};
    tv[13] = '{1, 'h20,  'h1,  0, 'h20,  0, 'h0,   'h0,  0, 1, 0, 'h0};
    tv[14] = '{1, 'h20,  'h2,  0, 'h20,  1, 'h20,  'h1,  1, 1, 1, 'h1};
    tv[15] = '{0, 'h0,   'h0,  0, 'h20,  1, 'h20,  'h1,  2, 1, 1, 'h2};
    tv[16] = '{0, 'h0,   'h0,  1, 'h20,  1, 'h20,  'h1,  2, 1, 1, 'h2};
    tv[17] = '{0, 'h0,   'h0,  1, 'h20,  1, 'h20,  'h2,  1, 1, 1, 'h2};
    tv[18] = '{0, 'h0,   'h0,  0, 'h20,  0, 'h0,   'h0,  0, 1, 0, 'h0};
    tv[19] = '{1, 'h30,  'hA,  0, 'h0,   0, 'h0,   'h0,  0, 1, 0, 'h0};
    tv[20] = '{1, 'h34,  'hB,  0, 'h0,   1, 'h30,  'hA,  1, 1, 0, 'h0};
    tv[21] = '{1, 'h38,  'hC,  1, 'h0,   1, 'h30,  'hA,  2, 1, 0, 'h0};
    tv[22] = '{0, 'h0,   'h0,  1, 'h0,   1, 'h34,  'hB,  2, 1, 0, 'h0};
    tv[23] = '{0, 'h0,   'h0,  1, 'h38,  1, 'h38,  'hC,  1, 1, 1, 'hC};
    tv[24] = '{0, 'h0,   'h0,  0, 'h38,  0, 'h0,   'h0,  0, 1, 0, 'h0};

    m_drain = 1'b0;
    drive(1, 0, '0, '0, 0, '0);
    tick();

    foreach (tv[i]) begin
      drive(0, tv[i].wr, tv[i].a, tv[i].d, tv[i].ack, tv[i].c);
      chk($sformatf("v%0d_wr_en", i), 64'(mem_wr_en), 64'(tv[i].en));
      chk($sformatf("v%0d_addr", i), 64'(mem_addr), 64'(tv[i].ma));
      chk($sformatf("v%0d_data", i), 64'(mem_w_data), 64'(tv[i].md));
      chk($sformatf("v%0d_count", i), 64'(count), 64'(tv[i].cnt));
      chk($sformatf("v%0d_empty", i), 64'(empty), 64'(tv[i].cnt == 0));
      chk($sformatf("v%0d_ready", i), 64'(wr_ready), 64'(tv[i].rdy));
      chk($sformatf("v%0d_hit", i), 64'(fwd_hit), 64'(tv[i].hit));
      chk($sformatf("v%0d_fdata", i), 64'(fwd_data), 64'(tv[i].fd));
      model_check();
      tick();
    end

    // Reset lands with three entries in flight, racing a push and an ack.
    step(0, 1, 'h50, 'h11, 0, 'h0);
    step(0, 1, 'h54, 'h22, 0, 'h0);
    step(0, 1, 'h58, 'h33, 0, 'h0);
    drive(0, 0, '0, '0, 0, 'h54);
    chk("rst_pre_count", 64'(count), 64'd3);
    chk("rst_pre_wr_en", 64'(mem_wr_en), 64'd1);
    tick();
    step(1, 1, 'h5C, 'h44, 1, 'h54);
    drive(0, 0, '0, '0, 0, 'h54);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rst_ready", 64'(wr_ready), 64'd1);
    chk("rst_hit", 64'(fwd_hit), 64'd0);
    chk("rst_maddr", 64'(mem_addr), 64'd0);
    model_check();
    tick();
    step(0, 0, '0, '0, 1, 'h5C);

    // Steady push/pop long enough to wrap both pointers.
    step(0, 1, 'h1000, 'hF00, 0, 'h0);
    for (int i = 1; i <= D + 2; i++)
      step(0, 1, AW'('h1000 + 4 * i), DW'('hF00 + i), 1,
           AW'('h1000 + 4 * (i - 1)));
    for (int i = 0; i < 3; i++)
      step(0, 0, '0, '0, 1, 'h1000 + AW'(4 * (D + 2)));

    // Random traffic over a small address pool to provoke hits.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] ra;
      logic [AW-1:0] rc;
      ra = AW'('h40 + 4 * $urandom_range(0, 3));
      rc = AW'('h40 + 4 * $urandom_range(0, 4));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6),
           ra, DW'($urandom), ($urandom_range(0, 1) == 1), rc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
